// File: rtl/fx_pkg.sv
// Shared FX bus defaults, FSM state encoding and slave return-bus index map.
package fx_pkg;

  localparam int FX_AW     = 22;
  localparam int FX_DW     = 8;
  localparam int FX_SW     = 6;
  localparam int FX_NS     = 36;
  localparam int FX_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_WAIT,
    ST_CAP
  } fx_state_e;

  // Slave return-bus indices, decoded from the top SW bits of the read address
  localparam int SL_CON  = 0;
  localparam int SL_APP  = 1;
  localparam int SL_CHIP = 2;
  localparam int SL_AD1  = 3;
  localparam int SL_DSP1 = 11;
  localparam int SL_P1   = 19;
  localparam int SL_AST1 = 27;

endpackage

// File: rtl/fx_rr_arb.sv
// Round-robin arbiter: first requester at or after pointer rr wins, one-hot grant.
module fx_rr_arb #(
  parameter int NM = 2,
  parameter int PW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] rr,
  output logic [NM-1:0] grant,
  output logic [PW-1:0] gidx,
  output logic          gvld
);

  int          idx;
  logic [PW-1:0] idx_p;

  always_comb begin
    grant = '0;
    gidx  = '0;
    gvld  = 1'b0;
    idx   = 0;
    idx_p = '0;
    for (int k = 0; k < NM; k++) begin
      idx   = (int'(rr) + k) % NM;
      idx_p = PW'(idx);
      if (!gvld && req[idx_p]) begin
        gvld         = 1'b1;
        grant[idx_p] = 1'b1;
        gidx         = idx_p;
      end
    end
  end

endmodule

// File: rtl/fx_bus_arb.sv
// Registered multi-master FX bus interconnect with decoded (muxed) slave read return.
module fx_bus_arb
  import fx_pkg::*;
#(
  parameter int NM     = 2,
  parameter int NS     = FX_NS,
  parameter int AW     = FX_AW,
  parameter int DW     = FX_DW,
  parameter int SW     = FX_SW,
  parameter int RD_LAT = 2
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [NM-1:0]    m_wr,
  input  logic [NM-1:0]    m_rd,
  input  logic [NM*AW-1:0] m_waddr,
  input  logic [NM*AW-1:0] m_raddr,
  input  logic [NM*DW-1:0] m_data,
  output logic [NM-1:0]    m_ack,
  output logic [DW-1:0]    m_q,
  output logic [NM-1:0]    m_qvld,
  output logic [NM-1:0]    m_err,
  output logic             fx_wr,
  output logic             fx_rd,
  output logic [AW-1:0]    fx_waddr,
  output logic [AW-1:0]    fx_raddr,
  output logic [DW-1:0]    fx_data,
  input  logic [NS*DW-1:0] s_q
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  fx_state_e           state_reg;
  logic [PW-1:0]       rr_reg;
  logic [PW-1:0]       g_reg;
  logic [FX_CNT_W-1:0] cnt_reg;

  logic [NM-1:0] req;
  logic [NM-1:0] grant;
  logic [PW-1:0] gidx;
  logic          gvld;
  logic [PW-1:0] rr_next;
  logic [NM-1:0] g_onehot;

  logic [DW-1:0] s_arr [NS];
  logic [SW-1:0] rd_idx;
  logic          idx_ok;

  assign req      = m_wr | m_rd;
  assign rr_next  = (gidx == PW'(NM - 1)) ? '0 : gidx + 1'b1;
  assign g_onehot = NM'(1) << g_reg;

  fx_rr_arb #(.NM(NM), .PW(PW)) u_arb (
    .req   (req),
    .rr    (rr_reg),
    .grant (grant),
    .gidx  (gidx),
    .gvld  (gvld)
  );

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_sl
      assign s_arr[gi] = s_q[gi*DW +: DW];
    end
  endgenerate

  // Only the addressed slave is selected; out-of-range indices return zero
  assign rd_idx = fx_raddr[AW-1 -: SW];
  assign idx_ok = (32'(rd_idx) < 32'(NS));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      rr_reg    <= '0;
      g_reg     <= '0;
      cnt_reg   <= '0;
      m_ack     <= '0;
      m_q       <= '0;
      m_qvld    <= '0;
      m_err     <= '0;
      fx_wr     <= 1'b0;
      fx_rd     <= 1'b0;
      fx_waddr  <= '0;
      fx_raddr  <= '0;
      fx_data   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (gvld) begin
            g_reg  <= gidx;
            rr_reg <= rr_next;
            // A simultaneous write+read from one master serves the write first
            if (m_wr[gidx]) begin
              state_reg <= ST_WR;
              fx_wr     <= 1'b1;
              fx_waddr  <= m_waddr[gidx*AW +: AW];
              fx_data   <= m_data[gidx*DW +: DW];
              m_ack     <= grant;
            end else begin
              state_reg <= ST_RD;
              fx_rd     <= 1'b1;
              fx_raddr  <= m_raddr[gidx*AW +: AW];
            end
          end
        end
        ST_WR: begin
          fx_wr     <= 1'b0;
          m_ack     <= '0;
          state_reg <= ST_IDLE;
        end
        ST_RD: begin
          fx_rd     <= 1'b0;
          cnt_reg   <= FX_CNT_W'(RD_LAT - 1);
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          // Capture on the last wait cycle so the pulses are visible during CAP
          if (cnt_reg == '0) begin
            state_reg <= ST_CAP;
            m_q       <= idx_ok ? s_arr[rd_idx] : '0;
            m_qvld    <= g_onehot;
            m_ack     <= g_onehot;
            m_err     <= idx_ok ? '0 : g_onehot;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_CAP: begin
          m_qvld    <= '0;
          m_ack     <= '0;
          m_err     <= '0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
